// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with DATA_W data bits, optional parity and 1 or 2 stop bits, LSB first.
// Optional feature: define UART_TX_BREAK_EN to add the break_i line-break input.
module uart_tx_param #(
  parameter int FREQUENCY = 50_000_000,
  parameter int SPEED     = 1_500_000,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              CLK_i,
  input  logic              reset_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef UART_TX_BREAK_EN
  input  logic              break_i,
`endif
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int DIV   = FREQUENCY / SPEED;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: FREQUENCY/SPEED must be at least 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_BREAK     = 3'd5,
    S_BREAK_REL = 3'd6
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              bit_tick;
  logic              line_lvl;

  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    logic p;
    if (PARITY == 2) begin
      p = ~^d;
    end else begin
      p = ^d;
    end
    return p;
  endfunction

  assign bit_tick = (baud_cnt == CNT_LAST);

  // Baud counter: parked at zero while idle or holding a break, wraps every DIV cycles otherwise
  always_ff @(posedge CLK_i) begin
    if (!reset_n) begin
      baud_cnt <= '0;
    end else if (state == S_IDLE || state == S_BREAK || bit_tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  // Line level implied by the current state; tx_o follows it one edge later
  always_comb begin
    line_lvl = 1'b1;
    case (state)
      S_IDLE:      line_lvl = 1'b1;
      S_START:     line_lvl = 1'b0;
      S_DATA:      line_lvl = shreg[0];
      S_PARITY:    line_lvl = par_bit;
      S_STOP:      line_lvl = 1'b1;
      S_BREAK:     line_lvl = 1'b0;
      S_BREAK_REL: line_lvl = 1'b1;
      default:     line_lvl = 1'b1;
    endcase
  end

  // Frame sequencer with registered handshake, busy and serial outputs
  always_ff @(posedge CLK_i) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      bit_cnt <= 4'd0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx_o    <= 1'b1;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      tx_o <= line_lvl;
      case (state)
        S_IDLE: begin
          bit_cnt <= 4'd0;
          if (valid_i && ready_o) begin
            shreg   <= data_i;
            par_bit <= parity_of(data_i);
            state   <= S_START;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
`ifdef UART_TX_BREAK_EN
          end else if (break_i) begin
            // Break drives the line low on this edge rather than one cycle late
            state   <= S_BREAK;
            tx_o    <= 1'b0;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
`endif
          end else begin
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        end
        S_START: begin
          if (bit_tick) begin
            state <= S_DATA;
          end else begin
            state <= S_START;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            shreg <= shreg >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= 4'd0;
              if (PARITY != 0) begin
                state <= S_PARITY;
              end else begin
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            state <= S_DATA;
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            state <= S_STOP;
          end else begin
            state <= S_PARITY;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= 4'd0;
              state   <= S_IDLE;
              ready_o <= 1'b1;
              busy_o  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            state <= S_STOP;
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          if (!break_i) begin
            state <= S_BREAK_REL;
            tx_o  <= 1'b1;
          end else begin
            tx_o  <= 1'b0;
          end
        end
        S_BREAK_REL: begin
          tx_o <= 1'b1;
          if (bit_tick) begin
            state   <= S_IDLE;
            ready_o <= 1'b1;
          end else begin
            state   <= S_BREAK_REL;
          end
        end
`endif
        default: begin
          state   <= S_IDLE;
          tx_o    <= 1'b1;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: three configurations, random words, line checked sample by sample.
module tb_uart_tx_param;

  localparam int DIV    = 4;
  localparam int N_RAND = 10;

  typedef struct {
    logic [8:0] word;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [8:0] din [3];
`ifdef UART_TX_BREAK_EN
  logic [2:0] brk;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int sent [3] = '{0, 0, 0};
  int done [3] = '{0, 0, 0};
  bit quiet_line = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param #(.FREQUENCY(8_000_000), .SPEED(2_000_000)) dut0 (
    .CLK_i(clk), .reset_n(reset_n), .valid_i(valid[0]), .data_i(din[0][7:0]),
`ifdef UART_TX_BREAK_EN
    .break_i(brk[0]),
`endif
    .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]));

  uart_tx_param #(.FREQUENCY(8_000_000), .SPEED(2_000_000), .DATA_W(7), .PARITY(1)) dut1 (
    .CLK_i(clk), .reset_n(reset_n), .valid_i(valid[1]), .data_i(din[1][6:0]),
`ifdef UART_TX_BREAK_EN
    .break_i(brk[1]),
`endif
    .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]));

  uart_tx_param #(.FREQUENCY(8_000_000), .SPEED(2_000_000), .DATA_W(9), .PARITY(2),
                  .STOP_BITS(2)) dut2 (
    .CLK_i(clk), .reset_n(reset_n), .valid_i(valid[2]), .data_i(din[2]),
`ifdef UART_TX_BREAK_EN
    .break_i(brk[2]),
`endif
    .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]));

  function automatic int cfg_dw(input int i);
    case (i)
      0:       return 8;
      1:       return 7;
      default: return 9;
    endcase
  endfunction

  function automatic int cfg_par(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_sb(input int i);
    case (i)
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  // Reference frame: start, data LSB first, optional parity, stop bits; returns bit count
  function automatic int frame_bits(input int i, input logic [8:0] w, output logic [15:0] lv);
    int n;
    int ones;
    lv   = '1;
    n    = 0;
    ones = 0;
    lv[n] = 1'b0;
    n++;
    for (int b = 0; b < cfg_dw(i); b++) begin
      lv[n] = w[b];
      if (w[b] == 1'b1) ones++;
      n++;
    end
    if (cfg_par(i) == 1) begin
      lv[n] = (ones % 2 == 1);
      n++;
    end else if (cfg_par(i) == 2) begin
      lv[n] = (ones % 2 == 0);
      n++;
    end
    for (int s = 0; s < cfg_sb(i); s++) begin
      lv[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  task automatic push_exp(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop_exp(input int i, output exp_t e);
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, i, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input int i);
    chk("reset_tx", i, 32'(tx[i]), 32'd1);
    chk("reset_ready", i, 32'(ready[i]), 32'd1);
    chk("reset_busy", i, 32'(busy[i]), 32'd0);
  endtask

  // Monitor: on each start bit pop the expected word and compare every line sample of the frame
  task automatic monitor(input int i);
    exp_t        e;
    logic [15:0] lv;
    int          len;
    int          bad;
    logic        bad_act;
    bit          abandoned;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && !quiet_line && tx[i] === 1'b0) begin
        if (qsize(i) == 0) begin
          chk("unexpected_frame", i, 32'd1, 32'd0);
          for (int w = 0; w < 64 && tx[i] !== 1'b1; w++) @(negedge clk);
        end else begin
          pop_exp(i, e);
          chk("start_latency", i, 32'(cyc), 32'(e.acc + 1));
          len       = frame_bits(i, e.word, lv);
          bad       = -1;
          bad_act   = 1'b0;
          abandoned = 1'b0;
          for (int k = 1; k < len * DIV; k++) begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
              abandoned = 1'b1;
              break;
            end
            if (bad < 0 && tx[i] !== lv[k / DIV]) begin
              bad     = k;
              bad_act = tx[i];
            end
          end
          if (!abandoned) begin
            n_tests++;
            if (bad >= 0) begin
              n_fail++;
              $display("FAIL frame dut%0d word=%0h: sample %0d got %b expected %b",
                       i, e.word, bad, bad_act, lv[bad / DIV]);
            end
            done[i]++;
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  // Offer one word, then time the ready/busy window; optionally poke a junk word mid-frame
  task automatic send(input int i, input logic [8:0] w, input bit junk);
    exp_t        e;
    logic [15:0] lv;
    int          t;
    int          n;
    int          nb;
    int          flen;
    t = 0;
    while (ready[i] !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_wait", i, 32'(t < 200), 32'd1);
    valid[i] = 1'b1;
    din[i]   = w;
    @(posedge clk); #1;
    e.word = w;
    e.acc  = cyc;
    push_exp(i, e);
    sent[i]++;
    valid[i] = 1'b0;
    din[i]   = 9'($urandom);
    flen = frame_bits(i, w, lv);
    n  = 0;
    nb = 0;
    while (ready[i] !== 1'b1 && n < 200) begin
      if (busy[i] === 1'b1) nb++;
      if (junk && n == 6) begin
        valid[i] = 1'b1;
        din[i]   = 9'h012;
      end else begin
        valid[i] = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    valid[i] = 1'b0;
    chk("ready_low_cycles", i, 32'(n), 32'(flen * DIV));
    chk("busy_cycles", i, 32'(nb), 32'(flen * DIV));
  endtask

  initial begin
    exp_t e;
    int   t;
    reset_n = 1'b0;
    valid   = 3'b000;
    for (int i = 0; i < 3; i++) din[i] = 9'h000;
`ifdef UART_TX_BREAK_EN
    brk = 3'b000;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_reset_vals(i);
    reset_n = 1'b1;
    @(posedge clk); #1;

    send(0, 9'h0A5, 1'b0);
    send(1, 9'h055, 1'b0);
    send(2, 9'h055, 1'b0);
    send(2, 9'h000, 1'b0);
    send(2, 9'h1FF, 1'b0);
    send(0, 9'h0C3, 1'b1);
    send(1, 9'h07F, 1'b1);

    for (int r = 0; r < N_RAND; r++) begin
      for (int i = 0; i < 3; i++) begin
        send(i, 9'($urandom), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end

    // Abandon a frame part way through its data bits
    valid[0] = 1'b1;
    din[0]   = 9'h03C;
    @(posedge clk); #1;
    e.word = 9'h03C;
    e.acc  = cyc;
    push_exp(0, e);
    valid[0] = 1'b0;
    repeat (3 * DIV) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals(0);
    reset_n = 1'b1;
    send(0, 9'h081, 1'b0);

`ifdef UART_TX_BREAK_EN
    begin
      int low;
      int hi;
      low = 0;
      hi  = 0;
      quiet_line = 1'b1;
      brk[0] = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (tx[0] === 1'b0 && ready[0] === 1'b0) low++;
      end
      brk[0] = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(posedge clk); #1;
        if (ready[0] === 1'b1) break;
        if (tx[0] === 1'b1) hi++;
      end
      quiet_line = 1'b0;
      chk("break_low_cycles", 0, 32'(low), 32'd20);
      chk("break_release_cycles", 0, 32'(hi), 32'(DIV));
      chk("break_ready_back", 0, 32'(ready[0]), 32'd1);
    end
`endif

    t = 0;
    while (t < 500 && !(done[0] == sent[0] && done[1] == sent[1] && done[2] == sent[2])) begin
      @(posedge clk); #1;
      t++;
    end
    for (int i = 0; i < 3; i++) chk("frames_completed", i, 32'(done[i]), 32'(sent[i]));
    chk("leftover_expected", 0, 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
